multiport_reg_file: RTL and testbench
=====================================

MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameter XLEN, default 64, data width of each register.
REQ-002 Parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 read_reg  in  NRD*AW  read address per port, port k at [k*AW +: AW].
REQ-009 read_data  out  NRD*XLEN  read data per port.
REQ-010 read_busy  out  NRD  1 = addressed register has a pending write (scoreboard set).
REQ-011 write_en  in  NWR  write enable per port.
REQ-012 write_reg  in  NWR*AW  write address per port.
REQ-013 write_data  in  NWR*XLEN  write data per port.
REQ-014 issue_en  in  1  marks issue_reg as pending (instruction issued with a destination).
REQ-015 issue_reg  in  AW  destination register being issued.
REQ-016 write_conflict  out  1  registered flag: two or more enabled write ports hit the same nonzero register last cycle.

Function
REQ-017 Register 0 SHALL read as zero on every port, ignore writes, never become pending.
REQ-018 Reads SHALL be combinational, zero-cycle latency from read_reg to read_data and read_busy.
REQ-019 Writes SHALL commit at the rising clock edge when write_en[j]=1 and write_reg[j]!=0.
REQ-020 Same-register multi-port write in one cycle: highest-index port SHALL win; write_conflict SHALL be 1 the following cycle, else 0.
REQ-021 BYPASS=1: read of a register being written this cycle SHALL return the winning write_data; BYPASS=0: SHALL return stored value.
REQ-022 Scoreboard: one pending bit per register; issue_en with issue_reg!=0 SHALL set the bit at the next edge.
REQ-023 A committed write to a register SHALL clear its pending bit at the next edge.
REQ-024 Issue and write to same register in one cycle: pending bit SHALL end set (issue wins).
REQ-025 read_busy[k] SHALL reflect stored pending bit; with BYPASS=1 it SHALL read 0 when the register is being written this cycle and not simultaneously issued.
REQ-026 Writes to register 0 SHALL not affect write_conflict.

Reset
REQ-027 reset=0 at a rising edge SHALL clear all registers to 0, all pending bits to 0, write_conflict to 0, overriding simultaneous writes/issues.
REQ-028 Reset asserted mid-operation SHALL discard in-flight pending state; no partial update survives.
REQ-029 During reset, read_data SHALL show stored (post-reset zero) values; no asynchronous path from reset.

Structure
REQ-030 A shared package SHALL hold XLEN/NREGS defaults, AW derivation and the register-index type.
REQ-031 Write-port priority/merge logic SHALL be a sub-module write_arbiter producing per-register winning enable and data.
REQ-032 Storage SHALL be a flat register array; no latches, no combinational write paths.

Verification
REQ-033 Reset, then read all registers on both ports -> all data 0, all read_busy 0, write_conflict 0.
REQ-034 Write port0 reg5=0x1234 while reading reg5 -> read_data=0x1234 same cycle (BYPASS=1); next cycle stored 0x1234.
REQ-035 Ports0/1 both write reg7 (0xAA, 0xBB) -> reg7=0xBB, write_conflict=1 one cycle then 0.
REQ-036 Issue reg9, two idle cycles, write reg9=0x55 -> read_busy=1 for two cycles, 0 in write cycle, data 0x55.
REQ-037 Write reg0=0xFFFF and issue reg0 -> reg0 reads 0, never busy; issue+write reg3 same cycle -> reg3 busy afterwards.
REQ-038 Issue reg4, write reg6=0x77, then reset=0 one edge -> reg6=0, reg4 not busy, write_conflict 0.

Source files
------------

// File: rtl/multiport_reg_file_pkg.sv
// Shared defaults, address-width derivation and register-index type for the
// multiport register file.
package multiport_reg_file_pkg;
  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;

  function automatic int aw_of(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int AW_DEF = $clog2(NREGS_DEF);
  typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/multiport_reg_file_if.sv
// Read, write and issue signals of the register file; master drives
// addresses and data, slave is the register file.
interface multiport_reg_file_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  import multiport_reg_file_pkg::*;
  localparam int AW = aw_of(NREGS);

  logic [NRD*AW-1:0]   read_reg;
  logic [NRD*XLEN-1:0] read_data;
  logic [NRD-1:0]      read_busy;
  logic [NWR-1:0]      write_en;
  logic [NWR*AW-1:0]   write_reg;
  logic [NWR*XLEN-1:0] write_data;
  logic                issue_en;
  logic [AW-1:0]       issue_reg;
  logic                write_conflict;

  modport master (
    output read_reg, write_en, write_reg, write_data, issue_en, issue_reg,
    input  read_data, read_busy, write_conflict
  );
  modport slave (
    input  read_reg, write_en, write_reg, write_data, issue_en, issue_reg,
    output read_data, read_busy, write_conflict
  );
endinterface

// File: rtl/multiport_reg_file_write_arbiter.sv
// Merges all write ports into one winning enable/data per register; later
// ports override earlier ones and any double hit raises conflict.
module write_arbiter
  import multiport_reg_file_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = aw_of(NREGS)
) (
  input  logic [NWR-1:0]              write_en,
  input  logic [NWR*AW-1:0]           write_reg,
  input  logic [NWR*XLEN-1:0]         write_data,
  output logic [NREGS-1:0]            reg_we,
  output logic [NREGS-1:0][XLEN-1:0]  reg_wdata,
  output logic                        conflict
);
  always_comb begin
    reg_we    = '0;
    reg_wdata = '0;
    conflict  = 1'b0;
    // Ascending scan: the highest-index enabled port is the last to land.
    for (int j = 0; j < NWR; j++) begin
      automatic logic [AW-1:0] wr = write_reg[j*AW +: AW];
      if (write_en[j] && wr != '0) begin
        if (reg_we[wr]) conflict = 1'b1;
        reg_we[wr]    = 1'b1;
        reg_wdata[wr] = write_data[j*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: rtl/multiport_reg_file.sv
// Multiport register file with zero register, optional same-cycle write
// forwarding and a per-register pending-write scoreboard.
module multiport_reg_file
  import multiport_reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = 1
) (
  input  logic               clock,
  input  logic               reset,
  multiport_reg_file_if.slave bus
);
  localparam int AW = aw_of(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           pend;
  logic [NREGS-1:0]           reg_we;
  logic [NREGS-1:0][XLEN-1:0] reg_wdata;
  logic [NREGS-1:0]           iss_hit;
  logic                       conflict_nxt;
  logic                       conflict_q;
  logic [NRD-1:0][XLEN-1:0]   rdata;
  logic [NRD-1:0]             rbusy;

  write_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .AW(AW)) u_arb (
    .write_en   (bus.write_en),
    .write_reg  (bus.write_reg),
    .write_data (bus.write_data),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .conflict   (conflict_nxt)
  );

  always_comb begin
    iss_hit = '0;
    if (bus.issue_en) iss_hit[bus.issue_reg] = 1'b1;
    iss_hit[0] = 1'b0;
  end

  // Register 0 is only ever touched by reset, so it stays zero and idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      regs       <= '0;
      pend       <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (reg_we[r]) regs[r] <= reg_wdata[r];
        if (iss_hit[r])     pend[r] <= 1'b1;
        else if (reg_we[r]) pend[r] <= 1'b0;
      end
      conflict_q <= conflict_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      automatic logic [AW-1:0] ra  = bus.read_reg[k*AW +: AW];
      automatic logic          fwd = (BYPASS != 0) && reg_we[ra];
      rdata[k] = fwd ? reg_wdata[ra] : regs[ra];
      // A write landing now retires the pending bit unless re-issued.
      rbusy[k] = pend[ra] & ~(fwd & ~iss_hit[ra]);
    end
  end

  assign bus.read_data      = rdata;
  assign bus.read_busy      = rbusy;
  assign bus.write_conflict = conflict_q;
endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed scenarios plus randomized traffic checked against an array-based
// model of the register file and its scoreboard.
module tb_multiport_reg_file;
  import multiport_reg_file_pkg::*;

  localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, BYPASS = 1;
  localparam int AW = $clog2(NREGS);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multiport_reg_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();
  multiport_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [XLEN-1:0] mdl [NREGS];
  bit              mpend [NREGS];
  bit              mconf;
  int nvec = 0;
  int nerr = 0;

  // Latest enabled port targeting r this cycle, if any.
  function automatic bit winner(input int r, output logic [XLEN-1:0] d);
    bit f = 0;
    d = '0;
    if (r == 0) return 0;
    for (int j = 0; j < NWR; j++)
      if (bus.write_en[j] && int'(bus.write_reg[j*AW +: AW]) == r) begin
        f = 1; d = bus.write_data[j*XLEN +: XLEN];
      end
    return f;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int r);
    logic [XLEN-1:0] d;
    if (r == 0) return '0;
    if (winner(r, d) && BYPASS != 0) return d;
    return mdl[r];
  endfunction

  function automatic bit exp_busy(input int r);
    logic [XLEN-1:0] d;
    bit iss = bus.issue_en && int'(bus.issue_reg) == r;
    return mpend[r] && !(BYPASS != 0 && winner(r, d) && !iss);
  endfunction

  task automatic idle();
    bus.write_en = '0; bus.write_reg = '0; bus.write_data = '0;
    bus.issue_en = 1'b0; bus.issue_reg = '0;
  endtask

  task automatic set_rd(input int k, input int r);
    bus.read_reg[k*AW +: AW] = AW'(r);
  endtask

  task automatic set_wr(input int j, input int r, input logic [XLEN-1:0] d);
    bus.write_en[j] = 1'b1;
    bus.write_reg[j*AW +: AW] = AW'(r);
    bus.write_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_iss(input int r);
    bus.issue_en = 1'b1; bus.issue_reg = AW'(r);
  endtask

  // Clock edge plus model update from the inputs held across it.
  task automatic step();
    @(posedge clock);
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin mdl[r] = '0; mpend[r] = 0; end
      mconf = 0;
    end else begin
      bit c = 0;
      for (int r = 1; r < NREGS; r++) begin
        int cnt = 0;
        logic [XLEN-1:0] d = '0;
        for (int j = 0; j < NWR; j++)
          if (bus.write_en[j] && int'(bus.write_reg[j*AW +: AW]) == r) begin
            cnt++; d = bus.write_data[j*XLEN +: XLEN];
          end
        if (cnt > 0) mdl[r] = d;
        if (cnt > 1) c = 1;
        if (bus.issue_en && int'(bus.issue_reg) == r) mpend[r] = 1;
        else if (cnt > 0) mpend[r] = 0;
      end
      mconf = c;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle(); reset = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      set_rd(0, r); set_rd(1, NREGS-1-r);
      #1;
      for (int k = 0; k < NRD; k++) begin
        nvec++;
        if (bus.read_data[k*XLEN +: XLEN] !== '0 || bus.read_busy[k] !== 1'b0) begin
          nerr++;
          $display("FAIL reset_read port%0d reg%0d: got %h busy %b want 0 busy 0", k, r,
                   bus.read_data[k*XLEN +: XLEN], bus.read_busy[k]);
        end
      end
    end
    nvec++;
    if (bus.write_conflict !== 1'b0) begin
      nerr++; $display("FAIL reset_conflict: got %b want 0", bus.write_conflict);
    end
    @(negedge clock);
  endtask

  task automatic test_bypass();
    idle(); set_wr(0, 5, 64'h1234); set_rd(0, 5);
    #2; nvec++;
    if (bus.read_data[0 +: XLEN] !== 64'h1234) begin
      nerr++; $display("FAIL bypass_same_cycle: got %h want 1234", bus.read_data[0 +: XLEN]);
    end
    step(); idle();
    #2; nvec++;
    if (bus.read_data[0 +: XLEN] !== 64'h1234) begin
      nerr++; $display("FAIL bypass_stored: got %h want 1234", bus.read_data[0 +: XLEN]);
    end
  endtask

  task automatic test_conflict();
    idle(); set_wr(0, 7, 64'hAA); set_wr(1, 7, 64'hBB);
    step(); idle(); set_rd(1, 7);
    #2; nvec++;
    if (bus.read_data[XLEN +: XLEN] !== 64'hBB || bus.write_conflict !== 1'b1) begin
      nerr++; $display("FAIL conflict_win: got %h conf %b want bb conf 1",
                       bus.read_data[XLEN +: XLEN], bus.write_conflict);
    end
    step();
    #2; nvec++;
    if (bus.write_conflict !== 1'b0) begin
      nerr++; $display("FAIL conflict_clear: got %b want 0", bus.write_conflict);
    end
  endtask

  task automatic test_scoreboard();
    idle(); set_iss(9); set_rd(0, 9);
    step(); idle();
    for (int c = 0; c < 2; c++) begin
      #2; nvec++;
      if (bus.read_busy[0] !== 1'b1) begin
        nerr++; $display("FAIL sb_pending cyc%0d: got %b want 1", c, bus.read_busy[0]);
      end
      step();
    end
    set_wr(1, 9, 64'h55);
    #2; nvec++;
    if (bus.read_busy[0] !== 1'b0 || bus.read_data[0 +: XLEN] !== 64'h55) begin
      nerr++; $display("FAIL sb_write_cycle: got busy %b data %h want 0 55",
                       bus.read_busy[0], bus.read_data[0 +: XLEN]);
    end
    step(); idle();
    #2; nvec++;
    if (bus.read_busy[0] !== 1'b0 || bus.read_data[0 +: XLEN] !== 64'h55) begin
      nerr++; $display("FAIL sb_retired: got busy %b data %h want 0 55",
                       bus.read_busy[0], bus.read_data[0 +: XLEN]);
    end
  endtask

  task automatic test_reg0();
    idle(); set_wr(0, 0, 64'hFFFF); set_wr(1, 0, 64'h1); set_iss(0);
    set_rd(0, 0); set_rd(1, 0);
    #2; nvec++;
    if (bus.read_data !== '0 || bus.read_busy !== '0) begin
      nerr++; $display("FAIL reg0_same: got %h busy %b want 0", bus.read_data, bus.read_busy);
    end
    step(); idle();
    #2; nvec++;
    if (bus.read_data !== '0 || bus.read_busy !== '0 || bus.write_conflict !== 1'b0) begin
      nerr++; $display("FAIL reg0_after: got %h busy %b conf %b want 0 0 0",
                       bus.read_data, bus.read_busy, bus.write_conflict);
    end
    set_iss(3); set_wr(1, 3, 64'h3333); set_rd(0, 3);
    step(); idle();
    #2; nvec++;
    if (bus.read_busy[0] !== 1'b1 || bus.read_data[0 +: XLEN] !== 64'h3333) begin
      nerr++; $display("FAIL issue_wins: got busy %b data %h want 1 3333",
                       bus.read_busy[0], bus.read_data[0 +: XLEN]);
    end
  endtask

  task automatic test_reset_mid();
    idle(); set_iss(4);
    step(); idle(); set_wr(0, 6, 64'h77);
    step(); idle();
    reset = 1'b0; set_wr(0, 6, 64'h99); set_wr(1, 6, 64'h98); set_iss(10);
    step(); reset = 1'b1; idle();
    set_rd(0, 6); set_rd(1, 4);
    #2; nvec++;
    if (bus.read_data[0 +: XLEN] !== '0 || bus.read_busy[1] !== 1'b0 ||
        bus.write_conflict !== 1'b0) begin
      nerr++; $display("FAIL mid_reset: got r6 %h busy4 %b conf %b want 0 0 0",
                       bus.read_data[0 +: XLEN], bus.read_busy[1], bus.write_conflict);
    end
    set_rd(0, 10);
    #1; nvec++;
    if (bus.read_busy[0] !== 1'b0) begin
      nerr++; $display("FAIL mid_reset_issue: got busy10 %b want 0", bus.read_busy[0]);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      idle();
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 1)) set_wr(j, $urandom_range(0, 7), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) set_iss($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++)
        set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7));
      #2;
      for (int k = 0; k < NRD; k++) begin
        int r = int'(bus.read_reg[k*AW +: AW]);
        nvec++;
        if (bus.read_data[k*XLEN +: XLEN] !== exp_data(r) || bus.read_busy[k] !== exp_busy(r)) begin
          nerr++;
          $display("FAIL rand_read n%0d port%0d reg%0d: got %h busy %b want %h busy %b", n, k, r,
                   bus.read_data[k*XLEN +: XLEN], bus.read_busy[k], exp_data(r), exp_busy(r));
        end
      end
      nvec++;
      if (bus.write_conflict !== mconf) begin
        nerr++; $display("FAIL rand_conflict n%0d: got %b want %b", n, bus.write_conflict, mconf);
      end
      step();
    end
    reset = 1'b1; idle();
  endtask

  initial begin
    idle(); bus.read_reg = '0;
    for (int r = 0; r < NREGS; r++) begin mdl[r] = '0; mpend[r] = 0; end
    mconf = 0;
    @(negedge clock);
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
